// File: rtl/fp_add_arb_if.sv
// Request/response bundle for the shared fixed-point adder arbiter.
// master = requesters and result consumer, slave = fp_add_arb.
interface fp_add_arb_if #(
  parameter int N_REQ = 4,
  parameter int I1    = 2,
  parameter int F1    = 14,
  parameter int I2    = 2,
  parameter int F2    = 14,
  parameter int I3    = 2,
  parameter int F3    = 13
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*(I1+F1)-1:0] req_a;
  logic [N_REQ-1:0]         req_s1;
  logic [N_REQ*(I2+F2)-1:0] req_b;
  logic [N_REQ-1:0]         req_s2;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [I3+F3-1:0]         rsp_c;
  logic                     rsp_sign;
  logic                     rsp_overflow;
  logic                     rsp_underflow;

  modport master (
    output req_valid, req_a, req_s1, req_b, req_s2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_sign, rsp_overflow, rsp_underflow
  );

  modport slave (
    input  req_valid, req_a, req_s1, req_b, req_s2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_c, rsp_sign, rsp_overflow, rsp_underflow
  );
endinterface

// File: rtl/fp_add_arb.sv
// Round-robin arbiter sharing one saturating fixed-point adder; one-entry result register.
// Define FP_ADD_ARB_STATS_EN to build the sticky overflow/underflow event counters.
module fp_add_arb #(
  parameter int N_REQ = 4,
  parameter int I1    = 2,
  parameter int F1    = 14,
  parameter int I2    = 2,
  parameter int F2    = 14,
  parameter int I3    = 2,
  parameter int F3    = 13
) (
  input  logic          clk,
  input  logic          rst,
  fp_add_arb_if.slave   bus,
  input  logic          cnt_clr,
  output logic [15:0]   ovf_count,
  output logic [15:0]   udf_count
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int W1  = I1 + F1;
  localparam int W2  = I2 + F2;
  localparam int W3  = I3 + F3;
  localparam int FM  = (F1 > F2) ? F1 : F2;
  localparam int IM  = ((I1 > I2) ? I1 : I2) + 1;
  localparam int WI  = IM + FM;
  localparam int DL  = FM - F3;
  localparam int KW  = WI - DL;
  localparam logic [WI-1:0] LO_MASK = (WI'(1) << DL) - WI'(1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic           allowed;

  // Round-robin search starting just after the last winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_idx = '0;
    grant_any = 1'b0;
    allowed   = !rst && (state == EMPTY || bus.rsp_ready);
    for (int k = 1; k <= N_REQ; k++) begin
      if (allowed && !grant_any && bus.req_valid[(int'(last) + k) % N_REQ]) begin
        grant_any = 1'b1;
        grant_idx = IDW'((int'(last) + k) % N_REQ);
      end
    end
    bus.req_ready = grant_any ? (N_REQ'(1) << grant_idx) : '0;
  end

  logic [W1-1:0] op_a;
  logic [W2-1:0] op_b;
  logic          s1, s2, sgn;
  logic [WI-1:0] ext_a, ext_b, sum;
  logic [KW-1:0] kept, sx;
  logic [W3-1:0] res, sat, c_next;
  logic          lost, ovf_next, udf_next;

  // Shared adder: align, extend, add at ideal width, then truncate and saturate.
  always_comb begin
    op_a = bus.req_a[int'(grant_idx) * W1 +: W1];
    op_b = bus.req_b[int'(grant_idx) * W2 +: W2];
    s1   = bus.req_s1[grant_idx];
    s2   = bus.req_s2[grant_idx];
    sgn  = s1 | s2;
    if (s1) ext_a = WI'($signed(op_a));
    else    ext_a = WI'(op_a);
    if (s2) ext_b = WI'($signed(op_b));
    else    ext_b = WI'(op_b);
    ext_a = ext_a << (FM - F1);
    ext_b = ext_b << (FM - F2);
    sum   = ext_a + ext_b;
    kept  = KW'(sum >> DL);
    lost  = |(sum & LO_MASK);
    res   = kept[W3-1:0];
    sx    = KW'($signed(res));
    if (sgn) begin
      ovf_next = (kept != sx);
      sat      = kept[KW-1] ? '0 : '1;
    end else begin
      ovf_next = ((kept >> W3) != '0);
      sat      = '1;
    end
    c_next   = ovf_next ? sat : res;
    udf_next = !ovf_next && (res == '0) && lost;
  end

  assign bus.rsp_valid = (state == FULL);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state             <= EMPTY;
      last              <= IDW'(N_REQ - 1);
      bus.rsp_id        <= '0;
      bus.rsp_c         <= '0;
      bus.rsp_sign      <= 1'b0;
      bus.rsp_overflow  <= 1'b0;
      bus.rsp_underflow <= 1'b0;
    end else if (grant_any) begin
      state             <= FULL;
      last              <= grant_idx;
      bus.rsp_id        <= grant_idx;
      bus.rsp_c         <= c_next;
      bus.rsp_sign      <= sgn;
      bus.rsp_overflow  <= ovf_next;
      bus.rsp_underflow <= udf_next;
    end else if (state == FULL && bus.rsp_ready) begin
      state <= EMPTY;
    end
  end

`ifdef FP_ADD_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ovf_count <= '0;
      udf_count <= '0;
    end else if (grant_any) begin
      if (ovf_next && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
      if (udf_next && udf_count != 16'hFFFF) udf_count <= udf_count + 16'd1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign ovf_count = '0;
  assign udf_count = '0;
`endif
endmodule

// File: doc/fp_add_arb.md
Name: fp_add_arb

Overview:
- Round-robin arbiter that shares one fixed-point adder datapath among N_REQ requesters.
- Each requester presents an operand pair with per-operand signedness.
- The granted pair passes through the combinational adder and is captured in a one-entry output register, tagged with the requester ID.
- Optional sticky overflow/underflow event counters feed the accelerator status block.

Parameters:
N_REQ, 4, number of requesters (2..16)
I1, 2, integer bits of operand a
F1, 14, fraction bits of operand a
I2, 2, integer bits of operand b
F2, 14, fraction bits of operand b
I3, 2, integer bits of result
F3, 13, fraction bits of result

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester operand pair valid
req_ready  out  N_REQ  one-hot grant; transfer when valid&ready
req_a  in  N_REQ*(I1+F1)  operand a, requester i at slice i
req_s1  in  N_REQ  operand a is two's complement
req_b  in  N_REQ*(I2+F2)  operand b, requester i at slice i
req_s2  in  N_REQ  operand b is two's complement
rsp_valid  out  1  result register holds a result
rsp_ready  in  1  consumer accepts result
rsp_id  out  max(1,$clog2(N_REQ))  index of requester that produced result
rsp_c  out  I3+F3  saturated/truncated sum
rsp_sign  out  1  result is signed (s1|s2)
rsp_overflow  out  1  sum saturated
rsp_underflow  out  1  nonzero sum truncated to zero
cnt_clr  in  1  synchronous clear of event counters
ovf_count  out  16  saturating count of captured overflows
udf_count  out  16  saturating count of captured underflows

Behaviour:
- Reset: rsp_valid=0; rsp_id, rsp_c and rsp flags=0; counters=0; RR pointer last=N_REQ-1, so requester 0 has first priority.
- FSM EMPTY/FULL, mirrored by rsp_valid.
  - EMPTY: grant allowed.
  - FULL & rsp_ready: result drains and a new grant is allowed in the same cycle; stays FULL if granted, else goes EMPTY.
  - FULL & !rsp_ready: no grant, all req_ready=0, result register held stable.
- Grant:
  - When allowed, req_ready[i]=1 for the first i with req_valid[i], searching last+1, last+2, … modulo N_REQ.
  - At most one bit set; req_ready may depend combinationally on req_valid and rsp_ready.
  - On grant, last←i.
  - Pointer unchanged when there is no grant.
- Latency: a result is visible on rsp_* exactly 1 cycle after the grant edge. Throughput is 1 per cycle while rsp_ready=1.
- Arithmetic (shared adder):
  - Operands are aligned to max(F1,F2) fraction bits.
  - Ideal width is max(I1,I2)+1 integer bits.
  - A signed operand is sign-extended; an unsigned operand is zero-extended.
  - Result takes the low F3 fraction bits by truncation, dropping max(F1,F2)-F3 LSBs.
- Unsigned case (s1=s2=0):
  - Overflow when the ideal integer part exceeds I3 bits.
  - On overflow, rsp_c = all ones.
- Signed case:
  - Overflow when dropped high bits are not a sign extension.
  - On overflow, saturate: negative → all zeros, positive → all ones.
- Underflow:
  - Set when the kept field is zero and the dropped LSBs are nonzero.
  - Never set together with overflow.
- Counters:
  - Increment on each capture whose flag is 1; hold at 0xFFFF.
  - cnt_clr wins over a simultaneous increment, leaving the counter at 0.
- rst mid-operation: a held result is discarded and the grant in that cycle is suppressed (req_ready=0 while rst=1).

Optional Feature:
- FP_ADD_ARB_STATS_EN defined: ovf_count/udf_count and cnt_clr behave as above.
- Undefined: counter registers are not built, ovf_count=udf_count=0 constant, cnt_clr is ignored; ports still exist.

Test Plan:
- Requester 2 only, a=0x4000, b=0x2000, s1=s2=0, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=2, rsp_c=0x3000, overflow=0, underflow=0.
- Unsigned a=0xC000, b=0xC000 → rsp_c=0x7FFF, rsp_overflow=1; with STATS_EN, ovf_count=1.
- Unsigned a=0x0001, b=0x0000 → rsp_c=0x0000, rsp_underflow=1; a=0x0002, b=0 → rsp_c=0x0001, underflow=0.
- All 4 req_valid held high, rsp_ready=1 → grants 0,1,2,3,0 on consecutive cycles; rsp_id follows one cycle later.
- Hold rsp_ready=0 for 3 cycles while FULL → req_ready=0, rsp_* stable; then rsp_ready=1 → drain and a new grant in the same cycle.
- Pulse rst while FULL → rsp_valid=0 next cycle, counters=0, next grant goes to requester 0. With ovf_count=0xFFFF plus an overflow capture → stays 0xFFFF; cnt_clr asserted in the same cycle as the capture → 0.
